// File: rtl/arkanoid_rom_pkg.sv
// rtl/arkanoid_rom_pkg.sv - shared Arkanoid ROM memory map and download sequencer types
//
// Purpose: one place for the download address map so the ROM selector and the
// download sequencer agree on bank boundaries and image length.
// Contents: dl_state_t sequencer states, bank base addresses, image length,
// saturating byte-count increment helper.
package arkanoid_rom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } dl_state_t;

  localparam int unsigned ADDR_W = 25;

  // Bank base addresses in download order; each bank ends where the next begins.
  localparam logic [ADDR_W-1:0] EPROM_1_BASE      = 25'h00000;
  localparam logic [ADDR_W-1:0] EPROM_2_BASE      = 25'h08000;
  localparam logic [ADDR_W-1:0] EPROM_3_BASE      = 25'h10000;
  localparam logic [ADDR_W-1:0] EPROM_4_BASE      = 25'h18000;
  localparam logic [ADDR_W-1:0] EPROM_5_BASE      = 25'h20000;
  localparam logic [ADDR_W-1:0] COLOR_PROM_1_BASE = 25'h28000;
  localparam logic [ADDR_W-1:0] COLOR_PROM_2_BASE = 25'h28200;
  localparam logic [ADDR_W-1:0] COLOR_PROM_3_BASE = 25'h28400;

  // Exact byte count of a complete image (one past the last color PROM byte).
  localparam logic [ADDR_W-1:0] EXPECTED_LEN      = 25'h28600;

  // Byte counter increment that sticks at all-ones so an oversized stream can
  // never wrap back to a length that looks correct.
  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (v == {ADDR_W{1'b1}}) ? v : v + 25'd1;
  endfunction

endpackage

// File: rtl/rom_download_seq_if.sv
// rtl/rom_download_seq_if.sv - download byte stream in, ROM bank write bus out
//
// Purpose: bundles the data_io download stream and the ioctl bank write bus.
// Signals:
//   dl_active   download in progress (level)
//   dl_index    image index, stable while dl_active=1
//   byte_valid  one-cycle strobe qualifying byte_data
//   byte_data   downloaded byte
//   ioctl_addr  bank write address
//   ioctl_dout  bank write data
//   ioctl_wr    one-cycle bank write pulse
// Modports:
//   master  the sequencer: consumes the stream, drives the write bus
//   slave   the stream source / bank side
interface rom_download_seq_if;

  logic        dl_active;
  logic [7:0]  dl_index;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;

  modport master (
    input  dl_active,
    input  dl_index,
    input  byte_valid,
    input  byte_data,
    output ioctl_addr,
    output ioctl_dout,
    output ioctl_wr
  );

  modport slave (
    output dl_active,
    output dl_index,
    output byte_valid,
    output byte_data,
    input  ioctl_addr,
    input  ioctl_dout,
    input  ioctl_wr
  );

endinterface

// File: rtl/rom_download_seq.sv
// rtl/rom_download_seq.sv - ROM image download sequencer for the Arkanoid ROM banks
//
// Purpose: turns the data_io byte stream of the ROM image into sequential bank
// writes, holds the game core in reset while loading, and reports completion,
// length error and an 8-bit checksum. Streams with any other index are ignored.
// Ports:
//   CLK_DL        download clock, all logic on its rising edge
//   RESET_N       synchronous active-low reset
//   dl_bus        download stream in / ioctl write bus out (master modport)
//   core_reset_n  low holds the game core in reset
//   load_done     last ROM download had exactly EXPECTED_LEN bytes
//   load_err      last ROM download length differed from EXPECTED_LEN
//   checksum      mod-256 sum of accepted bytes of the current/last ROM download
module rom_download_seq
  import arkanoid_rom_pkg::dl_state_t, arkanoid_rom_pkg::IDLE, arkanoid_rom_pkg::LOAD,
         arkanoid_rom_pkg::HOLD, arkanoid_rom_pkg::sat_inc;
#(
  parameter logic [7:0]  ROM_INDEX    = 8'h00,
  parameter logic [24:0] EXPECTED_LEN = arkanoid_rom_pkg::EXPECTED_LEN,
  parameter int unsigned HOLD_CYCLES  = 16
) (
  input  logic                      CLK_DL,
  input  logic                      RESET_N,
  rom_download_seq_if.master        dl_bus,
  output logic                      core_reset_n,
  output logic                      load_done,
  output logic                      load_err,
  output logic [7:0]                checksum
);

  localparam int unsigned      HCW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  dl_state_t      state_q,    state_d;
  logic [24:0]    count_q,    count_d;
  logic [7:0]     csum_q,     csum_d;
  logic [24:0]    addr_q,     addr_d;
  logic [7:0]     dout_q,     dout_d;
  logic           wr_q,       wr_d;
  logic           done_q,     done_d;
  logic           err_q,      err_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           armed_q,    armed_d;

  // State register and all datapath registers.
  always_ff @(posedge CLK_DL) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      count_q    <= '0;
      csum_q     <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_cnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_cnt_q <= hold_cnt_d;
      armed_q    <= armed_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    csum_d     = csum_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    wr_d       = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    hold_cnt_d = hold_cnt_q;
    // A download must be seen to start after reset: dl_active has to be low
    // for at least one cycle before IDLE may accept it. This ignores a stream
    // caught mid-flight by a reset, yet still lets a download that rose during
    // HOLD be picked up once IDLE is reached.
    armed_d    = armed_q | ~dl_bus.dl_active;

    unique case (state_q)
      IDLE: begin
        if (dl_bus.dl_active && armed_q && (dl_bus.dl_index == ROM_INDEX)) begin
          state_d = LOAD;
          count_d = '0;
          csum_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      LOAD: begin
        // A byte arriving in the same cycle dl_active drops is still accepted;
        // its write lands in the first HOLD cycle.
        if (dl_bus.byte_valid) begin
          if (count_q < EXPECTED_LEN) begin
            wr_d   = 1'b1;
            addr_d = count_q;
            dout_d = dl_bus.byte_data;
            csum_d = csum_q + dl_bus.byte_data;
          end
          count_d = sat_inc(count_q);
        end
        // Length check uses the updated count so a final coincident byte counts.
        if (!dl_bus.dl_active) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          err_d      = (count_d != EXPECTED_LEN);
          done_d     = (count_d == EXPECTED_LEN);
        end
      end

      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dl_bus.ioctl_addr = addr_q;
  assign dl_bus.ioctl_dout = dout_q;
  assign dl_bus.ioctl_wr   = wr_q;

  // The core only runs from a verified image; a failed load keeps it in reset.
  assign core_reset_n = (state_q == IDLE) && done_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign checksum     = csum_q;

endmodule

// File: tb/tb_rom_download_seq.sv
// tb/tb_rom_download_seq.sv - self-checking bench for rom_download_seq
module tb_rom_download_seq;

  localparam logic [24:0] LEN  = 25'h00600;
  localparam int          HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       core_reset_n;
  logic       load_done;
  logic       load_err;
  logic [7:0] checksum;

  always #5 clk = ~clk;

  rom_download_seq_if dl_bus ();

  rom_download_seq #(
    .ROM_INDEX    (8'h00),
    .EXPECTED_LEN (LEN),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .CLK_DL       (clk),
    .RESET_N      (rst_n),
    .dl_bus       (dl_bus),
    .core_reset_n (core_reset_n),
    .load_done    (load_done),
    .load_err     (load_err),
    .checksum     (checksum)
  );

  int total = 0;
  int bad   = 0;

  // Write monitor, sampled on the falling edge.
  int          wr_count = 0;
  logic [24:0] last_wr_addr = '0;
  always @(negedge clk) begin
    if (dl_bus.ioctl_wr === 1'b1) begin
      wr_count     = wr_count + 1;
      last_wr_addr = dl_bus.ioctl_addr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One strobe; the write for it must be visible right after the next edge.
  task automatic send_byte(input logic [7:0] data, input bit exp_wr, input logic [24:0] exp_addr);
    dl_bus.byte_valid = 1'b1;
    dl_bus.byte_data  = data;
    @(posedge clk); #1;
    dl_bus.byte_valid = 1'b0;
    check("wr_pulse", 32'(dl_bus.ioctl_wr), 32'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", 32'(dl_bus.ioctl_addr), 32'(exp_addr));
      check("wr_dout", 32'(dl_bus.ioctl_dout), 32'(data));
    end
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("gap_no_wr", 32'(dl_bus.ioctl_wr), 32'd0);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    dl_bus.dl_index  = idx;
    dl_bus.dl_active = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drops dl_active; rise = number of edges after the LOAD-exit edge at which
  // core_reset_n is first seen high (-1 if it stays low).
  task automatic end_dl(output int rise);
    dl_bus.dl_active = 1'b0;
    rise = -1;
    for (int k = 0; k <= HOLD + 4; k++) begin
      @(posedge clk); #1;
      if (rise < 0 && core_reset_n === 1'b1) rise = k;
    end
  endtask

  typedef struct {
    logic [7:0]  idx;
    int          nbytes;
    bit          use_addr;
    logic [7:0]  val;
    int          gapmax;
    int          exp_writes;
    logic [24:0] exp_last;
    bit          exp_done;
    bit          exp_err;
    logic [7:0]  exp_cs;
    int          exp_rise;
  } scen_t;

  scen_t tbl[4];

  initial begin
    int          rise;
    int          base;
    bit          acc;
    logic [7:0]  d;
    logic [7:0]  cs_exp;
    int          g;

    // full image, data = addr & 0xFF, sums to 0 mod 256
    tbl[0] = '{8'h00, int'(LEN),     1'b1, 8'h00, 0, int'(LEN), LEN - 25'd1, 1'b1, 1'b0, 8'h00, HOLD};
    // foreign index: nothing written, flags and core release unchanged
    tbl[1] = '{8'h01, 100,           1'b0, 8'h5A, 0, 0,         25'd0,       1'b1, 1'b0, 8'h00, 0};
    // two bytes too many: values 0x00,0x01 dropped and excluded from checksum
    tbl[2] = '{8'h00, int'(LEN) + 2, 1'b1, 8'h00, 0, int'(LEN), LEN - 25'd1, 1'b0, 1'b1, 8'h00, -1};
    // 16 x 0x11 with 0..3 cycle gaps: 0x110 -> 0x10, short image
    tbl[3] = '{8'h00, 16,            1'b0, 8'h11, 3, 16,        25'd15,      1'b0, 1'b1, 8'h10, -1};

    dl_bus.dl_active  = 1'b0;
    dl_bus.dl_index   = 8'h00;
    dl_bus.byte_valid = 1'b0;
    dl_bus.byte_data  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_addr",  32'(dl_bus.ioctl_addr), 32'd0);
    check("rst_dout",  32'(dl_bus.ioctl_dout), 32'd0);
    check("rst_wr",    32'(dl_bus.ioctl_wr),   32'd0);
    check("rst_core",  32'(core_reset_n),      32'd0);
    check("rst_done",  32'(load_done),         32'd0);
    check("rst_err",   32'(load_err),          32'd0);
    check("rst_cs",    32'(checksum),          32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 4; s++) begin
      base = wr_count;
      start_dl(tbl[s].idx);
      for (int i = 0; i < tbl[s].nbytes; i++) begin
        d   = tbl[s].use_addr ? 8'(i) : tbl[s].val;
        acc = (tbl[s].idx == 8'h00) && (i < int'(LEN));
        send_byte(d, acc, 25'(i));
        g = i % (tbl[s].gapmax + 1);
        gap(g);
      end
      end_dl(rise);
      check("scn_writes", 32'(wr_count - base), 32'(tbl[s].exp_writes));
      if (tbl[s].exp_writes > 0) check("scn_last_addr", 32'(last_wr_addr), 32'(tbl[s].exp_last));
      check("scn_done", 32'(load_done), 32'(tbl[s].exp_done));
      check("scn_err",  32'(load_err),  32'(tbl[s].exp_err));
      check("scn_cs",   32'(checksum),  32'(tbl[s].exp_cs));
      check("scn_rise", 32'(rise),      32'(tbl[s].exp_rise));
    end

    // Last byte strobed in the same cycle dl_active falls.
    start_dl(8'h00);
    cs_exp = 8'h00;
    for (int i = 0; i < int'(LEN) - 1; i++) begin
      send_byte(8'(i), 1'b1, 25'(i));
      cs_exp = cs_exp + 8'(i);
    end
    cs_exp = cs_exp + 8'hFF;
    dl_bus.byte_valid = 1'b1;
    dl_bus.byte_data  = 8'hFF;
    dl_bus.dl_active  = 1'b0;
    @(posedge clk); #1;
    dl_bus.byte_valid = 1'b0;
    check("fall_wr",   32'(dl_bus.ioctl_wr),   32'd1);
    check("fall_addr", 32'(dl_bus.ioctl_addr), 32'(LEN - 25'd1));
    check("fall_dout", 32'(dl_bus.ioctl_dout), 32'hFF);
    repeat (HOLD - 1) @(posedge clk);
    #1;
    check("fall_core_held", 32'(core_reset_n), 32'd0);
    @(posedge clk); #1;
    check("fall_core_rel",  32'(core_reset_n), 32'd1);
    check("fall_done", 32'(load_done), 32'd1);
    check("fall_err",  32'(load_err),  32'd0);
    check("fall_cs",   32'(checksum),  32'(cs_exp));

    // Reset pulse in the middle of a download.
    start_dl(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i + 3), 1'b1, 25'(i));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_addr", 32'(dl_bus.ioctl_addr), 32'd0);
    check("mid_rst_dout", 32'(dl_bus.ioctl_dout), 32'd0);
    check("mid_rst_wr",   32'(dl_bus.ioctl_wr),   32'd0);
    check("mid_rst_core", 32'(core_reset_n),      32'd0);
    check("mid_rst_done", 32'(load_done),         32'd0);
    check("mid_rst_err",  32'(load_err),          32'd0);
    check("mid_rst_cs",   32'(checksum),          32'd0);
    base = wr_count;
    for (int i = 0; i < 20; i++) send_byte(8'h77, 1'b0, 25'd0);
    check("mid_rst_nowr", 32'(wr_count - base), 32'd0);
    dl_bus.dl_active = 1'b0;
    @(posedge clk); #1;
    start_dl(8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'h22, 1'b1, 25'(i));
    end_dl(rise);
    check("fresh_err",  32'(load_err),  32'd1);
    check("fresh_done", 32'(load_done), 32'd0);
    check("fresh_cs",   32'(checksum),  32'h88);
    check("fresh_rise", 32'(rise),      32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
